// File: rtl/alu_op_scheduler.sv
// Two-requester ALU scheduler: round-robin grant, then a one-cycle execute, then a held response.
// Optional build macro ALU_SCHED_FLAGS_EN adds registered rsp_zero / rsp_neg result flags.
module alu_op_scheduler #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    input  logic         req1_valid,
    output logic         req0_ready,
    output logic         req1_ready,
    input  logic [2:0]   req0_op,
    input  logic [2:0]   req1_op,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [N-1:0] rsp_res,
    output logic         rsp_cout,
    output logic         busy
`ifdef ALU_SCHED_FLAGS_EN
    ,
    output logic         rsp_zero,
    output logic         rsp_neg
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [N:0] ONE_EXT = {{N{1'b0}}, 1'b1};

    state_t         state_q,     state_d;
    logic           ptr_q,       ptr_d;
    logic [2:0]     op_q,        op_d;
    logic [N-1:0]   a_q,         a_d;
    logic [N-1:0]   b_q,         b_d;
    logic           id_q,        id_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [N-1:0]   rsp_res_q,   rsp_res_d;
    logic           rsp_cout_q,  rsp_cout_d;
    logic           rsp_id_q,    rsp_id_d;
`ifdef ALU_SCHED_FLAGS_EN
    logic           rsp_zero_q,  rsp_zero_d;
    logic           rsp_neg_q,   rsp_neg_d;
`endif

    logic           any_valid;
    logic           grant_id;
    logic           accept;
    logic [N:0]     alu_out;

    // With both valid the pointer decides; otherwise the lone valid requester wins.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        grant_id  = (req0_valid && req1_valid) ? ptr_q : req1_valid;
        accept    = (state_q == ST_IDLE) && any_valid;
    end

    // Ready is gated by rst_n so it drops the instant reset asserts.
    assign req0_ready = rst_n && accept && !grant_id;
    assign req1_ready = rst_n && accept &&  grant_id;

    // Bit N carries the carry-out; -B reports carry exactly when B is zero.
    always_comb begin
        alu_out = '0;
        unique case (op_q)
            3'b000:  alu_out = {1'b0, b_q};
            3'b001:  alu_out = {1'b0, ~b_q};
            3'b010:  alu_out = {1'b0, a_q & b_q};
            3'b011:  alu_out = {1'b0, a_q | b_q};
            3'b100:  alu_out = {1'b0, a_q ^ b_q};
            3'b101:  alu_out = {1'b0, a_q} + {1'b0, b_q};
            3'b110:  alu_out = {1'b0, b_q} + ONE_EXT;
            default: alu_out = {(b_q == '0), (~b_q) + ONE_EXT[N-1:0]};
        endcase
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_res_d   = rsp_res_q;
        rsp_cout_d  = rsp_cout_q;
        rsp_id_d    = rsp_id_q;
`ifdef ALU_SCHED_FLAGS_EN
        rsp_zero_d  = rsp_zero_q;
        rsp_neg_d   = rsp_neg_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    id_d    = grant_id;
                    ptr_d   = ~grant_id;
                    op_d    = grant_id ? req1_op : req0_op;
                    a_d     = grant_id ? req1_a  : req0_a;
                    b_d     = grant_id ? req1_b  : req0_b;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_res_d   = alu_out[N-1:0];
                rsp_cout_d  = alu_out[N];
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
`ifdef ALU_SCHED_FLAGS_EN
                rsp_zero_d  = (alu_out[N-1:0] == '0);
                rsp_neg_d   = alu_out[N-1];
`endif
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                // Result fields stay as-is after hand-off; only valid drops.
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 1'b0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_res_q   <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_id_q    <= 1'b0;
`ifdef ALU_SCHED_FLAGS_EN
            rsp_zero_q  <= 1'b0;
            rsp_neg_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_res_q   <= rsp_res_d;
            rsp_cout_q  <= rsp_cout_d;
            rsp_id_q    <= rsp_id_d;
`ifdef ALU_SCHED_FLAGS_EN
            rsp_zero_q  <= rsp_zero_d;
            rsp_neg_q   <= rsp_neg_d;
`endif
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_res   = rsp_res_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != ST_IDLE);
`ifdef ALU_SCHED_FLAGS_EN
    assign rsp_zero  = rsp_zero_q;
    assign rsp_neg   = rsp_neg_q;
`endif

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Directed self-checking bench for alu_op_scheduler (N=8) with hand-computed expectations.
`timescale 1ns/1ps
module tb_alu_op_scheduler;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [2:0]   req0_op, req1_op;
    logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_cout, busy;
    logic [N-1:0] rsp_res;
`ifdef ALU_SCHED_FLAGS_EN
    logic         rsp_zero, rsp_neg;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    alu_op_scheduler #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .req0_op    (req0_op),
        .req1_op    (req1_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_res    (rsp_res),
        .rsp_cout   (rsp_cout),
        .busy       (busy)
`ifdef ALU_SCHED_FLAGS_EN
        ,
        .rsp_zero   (rsp_zero),
        .rsp_neg    (rsp_neg)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = %0h", tag, got);
        end
    endtask

    // Full single-requester transaction with rsp_ready held high; starts at a negedge in IDLE.
    task automatic run_op(input int k, input logic [2:0] op, input logic [N-1:0] a,
                          input logic [N-1:0] b, input logic [N-1:0] exp_res,
                          input logic exp_cout, input string tag);
        rsp_ready = 1'b1;
        if (k == 0) begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end
        #1;
        check({tag, "_ready0"}, 32'(req0_ready), 32'(k == 0));
        check({tag, "_ready1"}, 32'(req1_ready), 32'(k == 1));
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        check({tag, "_exec_busy"}, 32'(busy), 32'd1);
        check({tag, "_exec_valid"}, 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_res"}, 32'(rsp_res), 32'(exp_res));
        check({tag, "_cout"}, 32'(rsp_cout), 32'(exp_cout));
        check({tag, "_id"}, 32'(rsp_id), 32'(k));
        @(posedge clk); #1;
        check({tag, "_done_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_done_busy"}, 32'(busy), 32'd0);
        check({tag, "_held_res"}, 32'(rsp_res), 32'(exp_res));
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [N-1:0] sweep_res  [8];
    logic         sweep_cout [8];

    initial begin
        sweep_res  = '{8'h3C, 8'hC3, 8'h24, 8'hBD, 8'h99, 8'hE1, 8'h3D, 8'hC4};
        sweep_cout = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        req0_valid = 0; req1_valid = 0; rsp_ready = 1;
        req0_op = 0; req1_op = 0; req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        rst_n = 1'b0;
        @(negedge clk); #1;
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_res",   32'(rsp_res),   32'd0);
        check("rst_cout",  32'(rsp_cout),  32'd0);
        check("rst_id",    32'(rsp_id),    32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single request: F0 + 20 = 0x110
        run_op(0, 3'b101, 8'hF0, 8'h20, 8'h10, 1'b1, "single");

        for (int i = 0; i < 8; i++)
            run_op(0, 3'(i), 8'hA5, 8'h3C, sweep_res[i], sweep_cout[i], $sformatf("sweep_op%0d", i));

        // Backpressure on -0, with req1 waiting throughout the stall
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_op = 3'b111; req0_a = 8'h00; req0_b = 8'h00;
        #1;
        check("bp_ready0", 32'(req0_ready), 32'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_op = 3'b000; req1_b = 8'h5A;
        @(posedge clk); #1;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp_valid_c%0d", c), 32'(rsp_valid), 32'd1);
            check($sformatf("bp_res_c%0d", c),   32'(rsp_res),   32'h00);
            check($sformatf("bp_cout_c%0d", c),  32'(rsp_cout),  32'd1);
            check($sformatf("bp_rdy_c%0d", c),   32'({req1_ready, req0_ready}), 32'd0);
            if (c < 4) begin
                @(posedge clk); #1;
            end
        end
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", 32'(rsp_valid), 32'd0);
        check("bp_release_busy",  32'(busy),      32'd0);
        @(negedge clk);

        // Leave nonzero results and id=1 so the reset clear is observable
        run_op(1, 3'b101, 8'h12, 8'h34, 8'h46, 1'b0, "req1_add");

        // Reset in EXEC
        req0_valid = 1'b1; req0_op = 3'b101; req0_a = 8'h01; req0_b = 8'h01;
        #1;
        check("rm_ready0", 32'(req0_ready), 32'd1);
        @(posedge clk); #1;
        check("rm_exec_busy", 32'(busy), 32'd1);
        req1_valid = 1'b1; req1_op = 3'b000; req1_b = 8'h77;
        rst_n = 1'b0;
        #1;
        check("rm_valid", 32'(rsp_valid), 32'd0);
        check("rm_res",   32'(rsp_res),   32'd0);
        check("rm_cout",  32'(rsp_cout),  32'd0);
        check("rm_id",    32'(rsp_id),    32'd0);
        check("rm_busy",  32'(busy),      32'd0);
        check("rm_ready", 32'({req1_ready, req0_ready}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rm_after_ready0", 32'(req0_ready), 32'd1);
        check("rm_after_ready1", 32'(req1_ready), 32'd0);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #1;
        check("rm_after_valid", 32'(rsp_valid), 32'd1);
        check("rm_after_res",   32'(rsp_res),   32'h02);
        check("rm_after_id",    32'(rsp_id),    32'd0);
        @(negedge clk);

        // Contention from a fresh reset: grants must alternate starting at 0
        apply_reset();
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 3'b110; req0_b = 8'h01;
        req1_valid = 1'b1; req1_op = 3'b110; req1_b = 8'h01;
        for (int i = 0; i < 4; i++) begin
            int g;
            g = -1;
            for (int c = 0; c < 8 && g < 0; c++) begin
                #1;
                if (req0_ready) g = 0;
                else if (req1_ready) g = 1;
                if (g < 0) @(negedge clk);
            end
            check($sformatf("cont_grant%0d", i), 32'(g), 32'(i % 2));
            @(negedge clk); #1;
            check($sformatf("cont_exec_rdy%0d", i), 32'({req1_ready, req0_ready}), 32'd0);
            @(negedge clk);
            check($sformatf("cont_valid%0d", i), 32'(rsp_valid), 32'd1);
            check($sformatf("cont_res%0d", i),   32'(rsp_res),   32'h02);
            check($sformatf("cont_cout%0d", i),  32'(rsp_cout),  32'd0);
            check($sformatf("cont_id%0d", i),    32'(rsp_id),    32'(i % 2));
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (3) @(negedge clk);

`ifdef ALU_SCHED_FLAGS_EN
        run_op(0, 3'b100, 8'h55, 8'h55, 8'h00, 1'b0, "flag_xor");
        check("flag_xor_zero", 32'(rsp_zero), 32'd1);
        check("flag_xor_neg",  32'(rsp_neg),  32'd0);
        run_op(0, 3'b001, 8'h00, 8'h00, 8'hFF, 1'b0, "flag_not");
        check("flag_not_zero", 32'(rsp_zero), 32'd0);
        check("flag_not_neg",  32'(rsp_neg),  32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
